// File: rtl/resize_nearest_rd_ctrl.sv
// Nearest-neighbour resize read controller.
// Walks the destination raster, maps each output pixel back to a source
// (row, column) with fixed-point accumulators, and issues line-buffer reads.
// It also frees each source row once no later output row needs it.
// Optional feature macro: RESIZE_RD_CTRL_MARKER_EN adds sof_o/eol_o markers.
// The markers are delayed two cycles to line up with the line buffer's valid_o.
// When the macro is undefined, sof_o and eol_o are tied low.
module resize_nearest_rd_ctrl #(
   parameter int FRAC_BITS = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [10:0]            src_width,
   input  logic [10:0]            src_height,
   input  logic [10:0]            dst_width,
   input  logic [10:0]            dst_height,
   input  logic [11+FRAC_BITS-1:0] x_step,
   input  logic [11+FRAC_BITS-1:0] y_step,
   input  logic                   start,
   input  logic                   rd_ready,
   output logic                   rd_en,
   output logic [10:0]            rd_addr,
   output logic                   rd_finish,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   sof_o,
   output logic                   eol_o
);

   localparam int ACC_W = 11 + FRAC_BITS;

   typedef enum logic [2:0] {
      IDLE, WAIT_ROW, READ_ROW, ROW_END, RELEASE, SETTLE, DRAIN, DONE
   } state_t;

   state_t           state, ret_state;
   logic [10:0]      src_w_q, src_h_q, dst_w_q, dst_h_q;
   logic [ACC_W-1:0] x_step_q, y_step_q;
   logic [ACC_W-1:0] acc_x, acc_y;
   logic [10:0]      dst_x, dst_y, cur_row;
   logic [10:0]      src_x, src_y;
   logic             row_go;

   // Accumulators stick at full scale instead of wrapping; the clamp below
   // then pins the index to the last source pixel.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction

   function automatic logic [10:0] clamp_idx(input logic [ACC_W-1:0] acc,
                                             input logic [10:0]      size);
      logic [10:0] idx;
      logic [10:0] lim;
      idx = acc[ACC_W-1:FRAC_BITS];
      lim = size - 11'd1;
      return (idx > lim) ? lim : idx;
   endfunction

   assign src_x  = clamp_idx(acc_x, src_w_q);
   assign src_y  = clamp_idx(acc_y, src_h_q);
   // Buffer head already holds the needed row: start reading it this cycle.
   assign row_go = (state == WAIT_ROW) && rd_ready && (src_y <= cur_row);

   // Frame sequencer: raster walk, row release and frame completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ret_state  <= IDLE;
         src_w_q    <= '0;
         src_h_q    <= '0;
         dst_w_q    <= '0;
         dst_h_q    <= '0;
         x_step_q   <= '0;
         y_step_q   <= '0;
         acc_x      <= '0;
         acc_y      <= '0;
         dst_x      <= '0;
         dst_y      <= '0;
         cur_row    <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         rd_finish  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         rd_finish  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  src_w_q  <= src_width;
                  src_h_q  <= src_height;
                  dst_w_q  <= dst_width;
                  dst_h_q  <= dst_height;
                  x_step_q <= x_step;
                  y_step_q <= y_step;
                  acc_x    <= '0;
                  acc_y    <= '0;
                  dst_x    <= '0;
                  dst_y    <= '0;
                  cur_row  <= '0;
                  busy     <= 1'b1;
                  state    <= (dst_width == 11'd0 || dst_height == 11'd0) ? DRAIN : WAIT_ROW;
               end
            end
            WAIT_ROW: begin
               if (row_go) begin
                  rd_en   <= 1'b1;
                  rd_addr <= src_x;
                  acc_x   <= sat_add(acc_x, x_step_q);
                  dst_x   <= 11'd1;
                  state   <= READ_ROW;
               end else if (rd_ready) begin
                  rd_finish <= 1'b1;
                  ret_state <= WAIT_ROW;
                  state     <= RELEASE;
               end
            end
            READ_ROW: begin
               if (dst_x == dst_w_q) begin
                  rd_en   <= 1'b0;
                  rd_addr <= '0;
                  state   <= ROW_END;
               end else begin
                  rd_addr <= src_x;
                  acc_x   <= sat_add(acc_x, x_step_q);
                  dst_x   <= dst_x + 11'd1;
               end
            end
            ROW_END: begin
               acc_x <= '0;
               dst_x <= '0;
               acc_y <= sat_add(acc_y, y_step_q);
               dst_y <= dst_y + 11'd1;
               state <= ((dst_y + 11'd1) == dst_h_q) ? DRAIN : WAIT_ROW;
            end
            RELEASE: begin
               cur_row <= cur_row + 11'd1;
               state   <= SETTLE;
            end
            // rd_ready still reflects the row just released; skip one cycle.
            SETTLE: state <= ret_state;
            DRAIN: begin
               if (cur_row < src_h_q) begin
                  if (rd_ready) begin
                     rd_finish <= 1'b1;
                     ret_state <= DRAIN;
                     state     <= RELEASE;
                  end
               end else begin
                  frame_done <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RESIZE_RD_CTRL_MARKER_EN
   logic sof_p0, sof_p1, sof_p2;
   logic eol_p0, eol_p1, eol_p2;

   // Markers generated in step with rd_en, then delayed to match valid_o.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sof_p0 <= 1'b0;
         eol_p0 <= 1'b0;
      end else begin
         sof_p0 <= row_go && (dst_y == 11'd0);
         eol_p0 <= (row_go && (dst_w_q == 11'd1)) ||
                   ((state == READ_ROW) && (dst_x != dst_w_q) &&
                    ((dst_x + 11'd1) == dst_w_q));
      end
   end

   // ---- stage p0 -> p1 -> p2: two-cycle line-buffer read latency ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sof_p1 <= 1'b0;
         sof_p2 <= 1'b0;
         eol_p1 <= 1'b0;
         eol_p2 <= 1'b0;
      end else begin
         sof_p1 <= sof_p0;
         sof_p2 <= sof_p1;
         eol_p1 <= eol_p0;
         eol_p2 <= eol_p1;
      end
   end

   assign sof_o = sof_p2;
   assign eol_o = eol_p2;
`else
   assign sof_o = 1'b0;
   assign eol_o = 1'b0;
`endif

endmodule

// File: tb/tb_resize_nearest_rd_ctrl.sv
// Bench for resize_nearest_rd_ctrl: a reference raster model fills a
// scoreboard of expected read/release/done events, and a negedge monitor
// pops and compares each event the DUT produces.
module tb_resize_nearest_rd_ctrl;

   localparam int FB = 16;
   localparam int SW = 11 + FB;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [10:0]   src_width = '0, src_height = '0, dst_width = '0, dst_height = '0;
   logic [SW-1:0] x_step = '0, y_step = '0;
   logic          start = 1'b0;
   logic          rd_ready = 1'b1;
   logic          rd_en, rd_finish, busy, frame_done, sof_o, eol_o;
   logic [10:0]   rd_addr;

   typedef struct {
      int kind;   // 0 read, 1 release, 2 frame done
      int addr;
      bit sof;
      bit eol;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  ev_cnt = 0;
   int  done_cnt = 0;
   bit  mon_en = 1'b0;
   bit  sd1 = 1'b0, sd2 = 1'b0, ed1 = 1'b0, ed2 = 1'b0;

   resize_nearest_rd_ctrl #(.FRAC_BITS(FB)) dut (
      .clk(clk), .reset_n(reset_n),
      .src_width(src_width), .src_height(src_height),
      .dst_width(dst_width), .dst_height(dst_height),
      .x_step(x_step), .y_step(y_step),
      .start(start), .rd_ready(rd_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_finish(rd_finish),
      .busy(busy), .frame_done(frame_done),
      .sof_o(sof_o), .eol_o(eol_o)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor
   ev_t m_e;
   int  m_kind;
   bit  m_sof, m_eol;
   always @(negedge clk) begin
      if (!reset_n || !mon_en) begin
         sd1 = 0; sd2 = 0; ed1 = 0; ed2 = 0;
      end else begin
         m_sof = 0; m_eol = 0;
         tests++;
         if (rd_en && rd_finish) begin
            fails++;
            $display("FAIL rd_en_rd_finish_overlap: both 1, required not both");
         end
         if (rd_en || rd_finish || frame_done) begin
            ev_cnt++;
            m_kind = rd_en ? 0 : (rd_finish ? 1 : 2);
            if (m_kind == 2) done_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_event: kind=%0d addr=%0d, required no event", m_kind, rd_addr);
            end else begin
               m_e = exp_q.pop_front();
               if (m_kind !== m_e.kind || (m_kind == 0 && int'(rd_addr) !== m_e.addr)) begin
                  fails++;
                  $display("FAIL event_seq: kind=%0d addr=%0d, required kind=%0d addr=%0d",
                           m_kind, rd_addr, m_e.kind, m_e.addr);
               end
`ifdef RESIZE_RD_CTRL_MARKER_EN
               if (m_kind == 0) begin m_sof = m_e.sof; m_eol = m_e.eol; end
`endif
            end
         end
         tests++;
         if (sof_o !== sd2 || eol_o !== ed2) begin
            fails++;
            $display("FAIL markers: sof_o=%b eol_o=%b, required sof_o=%b eol_o=%b", sof_o, eol_o, sd2, ed2);
         end
         sd2 = sd1; sd1 = m_sof;
         ed2 = ed1; ed1 = m_eol;
      end
   end

   // Reference model: nearest-neighbour mapping with clamping.
   task automatic build_exp(input int sw, input int sh, input int dw, input int dh,
                            input int xs, input int ys);
      ev_t e;
      int  cur, sy, sx;
      cur = 0;
      if (dw != 0 && dh != 0) begin
         for (int y = 0; y < dh; y++) begin
            sy = (y * ys) >> FB;
            if (sy > sh - 1) sy = sh - 1;
            while (cur < sy) begin
               e = '{kind: 1, addr: 0, sof: 1'b0, eol: 1'b0};
               exp_q.push_back(e);
               cur++;
            end
            for (int x = 0; x < dw; x++) begin
               sx = (x * xs) >> FB;
               if (sx > sw - 1) sx = sw - 1;
               e = '{kind: 0, addr: sx, sof: (x == 0 && y == 0), eol: (x == dw - 1)};
               exp_q.push_back(e);
            end
         end
      end
      while (cur < sh) begin
         e = '{kind: 1, addr: 0, sof: 1'b0, eol: 1'b0};
         exp_q.push_back(e);
         cur++;
      end
      e = '{kind: 2, addr: 0, sof: 1'b0, eol: 1'b0};
      exp_q.push_back(e);
   endtask

   task automatic start_frame(input int sw, input int sh, input int dw, input int dh,
                              input int xs, input int ys);
      @(posedge clk); #1;
      src_width = sw[10:0]; src_height = sh[10:0];
      dst_width = dw[10:0]; dst_height = dh[10:0];
      x_step = xs[SW-1:0];  y_step = ys[SW-1:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, output bit ok);
      int n;
      n = 0;
      while (done_cnt == base && n < budget) begin
         @(posedge clk);
         n++;
      end
      ok = (done_cnt != base);
   endtask

   task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                            input int xs, input int ys, output bit ok);
      int base;
      base = done_cnt;
      build_exp(sw, sh, dw, dh, xs, ys);
      start_frame(sw, sh, dw, dh, xs, ys);
      wait_done(base, 2000, ok);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (rd_en !== 1'b0 || rd_finish !== 1'b0 || rd_addr !== 11'd0) begin
         fails++;
         $display("FAIL reset_rd: rd_en=%b rd_finish=%b rd_addr=%0d, required 0 0 0", rd_en, rd_finish, rd_addr);
      end
      tests++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_status: busy=%b frame_done=%b, required 0 0", busy, frame_done);
      end
      tests++;
      if (sof_o !== 1'b0 || eol_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_markers: sof_o=%b eol_o=%b, required 0 0", sof_o, eol_o);
      end
      reset_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_identity();
      bit ok;
      run_frame(4, 2, 4, 2, 'h10000, 'h10000, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL identity_timeout: no frame_done, required frame_done"); end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL identity_left: %0d events pending, required 0", exp_q.size()); end
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL identity_busy: busy=%b, required 0", busy); end
   endtask

   task automatic test_upscale();
      bit ok;
      run_frame(2, 2, 4, 4, 'h8000, 'h8000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
         fails++;
         $display("FAIL upscale: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
   endtask

   task automatic test_downscale();
      bit ok;
      run_frame(4, 4, 2, 2, 'h20000, 'h20000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
         fails++;
         $display("FAIL downscale: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
   endtask

   task automatic test_clamp();
      bit ok;
      run_frame(3, 3, 5, 4, 'h10000, 'h10000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
         fails++;
         $display("FAIL clamp: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
   endtask

   task automatic test_zero_dst();
      bit ok;
      run_frame(2, 3, 4, 0, 'h10000, 'h10000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
         fails++;
         $display("FAIL zero_dst_h: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
      run_frame(2, 2, 0, 3, 'h10000, 'h10000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
         fails++;
         $display("FAIL zero_dst_w: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
   endtask

   task automatic test_stall();
      bit ok;
      int base_ev, base_done, n;
      base_ev = ev_cnt;
      base_done = done_cnt;
      build_exp(4, 2, 4, 2, 'h10000, 'h10000);
      start_frame(4, 2, 4, 2, 'h10000, 'h10000);
      n = 0;
      while (ev_cnt < base_ev + 4 && n < 500) begin @(posedge clk); n++; end
      #1;
      rd_ready = 1'b0;
      tests++;
      if (ev_cnt < base_ev + 4) begin fails++; $display("FAIL stall_row0: %0d events, required 4", ev_cnt - base_ev); end
      repeat (50) @(posedge clk);
      #1;
      tests++;
      if (ev_cnt != base_ev + 4) begin
         fails++;
         $display("FAIL stall_quiet: %0d events, required 4", ev_cnt - base_ev);
      end
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy: busy=%b, required 1", busy); end
      rd_ready = 1'b1;
      wait_done(base_done, 2000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
         fails++;
         $display("FAIL stall_resume: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
   endtask

   task automatic test_busy_ignore();
      bit ok;
      int base;
      base = done_cnt;
      build_exp(4, 2, 4, 2, 'h10000, 'h10000);
      start_frame(4, 2, 4, 2, 'h10000, 'h10000);
      repeat (3) @(posedge clk);
      #1;
      src_width = 11'd2; src_height = 11'd2; dst_width = 11'd3; dst_height = 11'd3;
      x_step = SW'('h8000); y_step = SW'('h8000);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(base, 2000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
         fails++;
         $display("FAIL busy_ignore: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL busy_ignore_idle: busy=%b, required 0", busy); end
   endtask

   task automatic test_mid_reset();
      bit ok;
      int base_ev, n;
      base_ev = ev_cnt;
      build_exp(4, 2, 4, 2, 'h10000, 'h10000);
      start_frame(4, 2, 4, 2, 'h10000, 'h10000);
      n = 0;
      while (ev_cnt < base_ev + 7 && n < 500) begin @(posedge clk); n++; end
      #1;
      mon_en = 1'b0;
      reset_n = 1'b0;
      tests++;
      if (ev_cnt != base_ev + 7) begin fails++; $display("FAIL mid_reset_reach: %0d events, required 7", ev_cnt - base_ev); end
      #2;
      tests++;
      if ({rd_en, rd_finish, frame_done, sof_o, eol_o} !== 5'b0 || rd_addr !== 11'd0) begin
         fails++;
         $display("FAIL mid_reset_outputs: rd_en=%b rd_finish=%b done=%b sof=%b eol=%b addr=%0d, required all 0",
                  rd_en, rd_finish, frame_done, sof_o, eol_o, rd_addr);
      end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: busy=%b, required 0", busy); end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en = 1'b1;
      run_frame(4, 2, 4, 2, 'h10000, 'h10000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
         fails++;
         $display("FAIL mid_reset_restart: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2;
      run_frame(3, 2, 6, 3, 'h8000, 'hAAAA, ok1);
      run_frame(5, 3, 2, 2, 'h28000, 'h18000, ok2);
      tests++;
      if (!ok1 || !ok2 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL back_to_back: done=%b%b pending=%0d, required done=11 pending=0", ok1, ok2, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_upscale();
      test_downscale();
      test_clamp();
      test_zero_dst();
      test_stall();
      test_busy_ignore();
      test_mid_reset();
      test_back_to_back();
      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
